// File: rtl/spi_flash_init_ctrl.sv
// spi_flash_init_ctrl: SPI mode-0 initiator that takes the quad flash from
// power-up to quad-ready. On start it sends WREN (0x06), then WRSR (0x01 + SR1,
// SR2), then polls RDSR (0x05) until BUSY clears or POLL_LIMIT frames have run.
// Optional feature: define SPI_FLASH_INIT_VERIFY_EN to also compare the final
// captured SR1[7:2] against the written value and flag a mismatch as error.
module spi_flash_init_ctrl #(
  parameter int unsigned CLK_DIV    = 2,   // ACLK cycles per SCLK half-period
  parameter int unsigned CS_GAP     = 4,   // min ACLK cycles CS high between frames
  parameter int unsigned POLL_LIMIT = 255  // max RDSR frames before error
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        start,
  input  logic [15:0] status_value,
  output logic        CS,
  output logic        CLOCK,
  output logic        IO0,
  input  logic        IO1,
  output logic        IO2,
  output logic        IO3,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  poll_count
);

  typedef enum logic [3:0] {
    IDLE, WREN, GAP1, WRSR, GAP2, RDSR, GAP3, CHECK, FIN
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);
  localparam logic [7:0]  POLL_MAX = 8'(POLL_LIMIT);

  state_t      state_q, state_d;
  logic [23:0] sh_q;
  logic [23:0] frame_word;
  logic [4:0]  bit_q;
  logic [4:0]  nbits;
  logic [15:0] div_q;
  logic [15:0] gap_q;
  logic        active_q;
  logic        cs_q;
  logic        sclk_q;
  logic        io0_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] sr_lat_q;
  logic [7:0]  pcnt_q;

  logic        frame_state;
  logic        in_gap;
  logic        launch;
  logic        half_tick;
  logic        last_bit;
  logic        frame_end;
  logic        gap_done;
  logic        accept;
  logic        set_done;
  logic        set_error;
  logic        busy_bit;

`ifdef SPI_FLASH_INIT_VERIFY_EN
  logic [7:0]  rx_q;
  logic        sr1_match;
  assign busy_bit  = rx_q[0];
  assign sr1_match = (rx_q[7:2] == sr_lat_q[15:10]);
`else
  logic        rx_bit_q;
  assign busy_bit  = rx_bit_q;
`endif

  assign frame_state = (state_q == WREN) || (state_q == WRSR) || (state_q == RDSR);
  assign in_gap      = (state_q == GAP1) || (state_q == GAP2) || (state_q == GAP3);
  // Each frame state spends one cycle with CS still high to load the shifter.
  assign launch      = frame_state && !active_q;
  assign half_tick   = (div_q == DIV_LAST);
  assign last_bit    = (bit_q == nbits - 5'd1);
  assign frame_end   = active_q && half_tick && sclk_q && last_bit;
  assign gap_done    = (gap_q == GAP_LAST);
  assign accept      = start && ((state_q == IDLE) || (state_q == FIN));

  assign CS         = cs_q;
  assign CLOCK      = sclk_q;
  assign IO0        = io0_q;
  assign IO2        = 1'b1;
  assign IO3        = 1'b1;
  assign busy       = (state_q != IDLE) && (state_q != FIN);
  assign done       = done_q;
  assign error      = error_q;
  assign poll_count = pcnt_q;

  // Frame length and left-aligned payload for the current frame state.
  always_comb begin
    nbits      = 5'd16;
    frame_word = {8'h05, 16'h0000};
    case (state_q)
      WREN: begin
        nbits      = 5'd8;
        frame_word = {8'h06, 16'h0000};
      end
      WRSR: begin
        nbits      = 5'd24;
        frame_word = {8'h01, sr_lat_q};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic plus done/error set requests out of CHECK.
  always_comb begin
    state_d   = state_q;
    set_done  = 1'b0;
    set_error = 1'b0;
    case (state_q)
      IDLE, FIN: if (start) state_d = WREN;
      WREN:      if (frame_end) state_d = GAP1;
      GAP1:      if (gap_done) state_d = WRSR;
      WRSR:      if (frame_end) state_d = GAP2;
      GAP2:      if (gap_done) state_d = RDSR;
      RDSR:      if (frame_end) state_d = CHECK;
      GAP3:      if (gap_done) state_d = RDSR;
      CHECK: begin
        if (!busy_bit) begin
          state_d  = FIN;
          set_done = 1'b1;
`ifdef SPI_FLASH_INIT_VERIFY_EN
          set_error = !sr1_match;
`endif
        end else if (pcnt_q == POLL_MAX) begin
          state_d   = FIN;
          set_done  = 1'b1;
          set_error = 1'b1;
        end else begin
          state_d = GAP3;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // Run status: latch on accepted start, sticky done/error, gap timer.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sr_lat_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      gap_q    <= '0;
    end else begin
      if (accept) begin
        sr_lat_q <= status_value;
        done_q   <= 1'b0;
        error_q  <= 1'b0;
      end
      if (set_done)  done_q  <= 1'b1;
      if (set_error) error_q <= 1'b1;
      gap_q <= in_gap ? gap_q + 16'd1 : '0;
    end
  end

  // SPI frame engine: SCLK low then high for CLK_DIV cycles per bit; MOSI
  // shifts on SCLK fall, MISO sampled on the edge that raises SCLK.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      active_q <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      io0_q    <= 1'b0;
      sh_q     <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      pcnt_q   <= '0;
`ifdef SPI_FLASH_INIT_VERIFY_EN
      rx_q     <= '0;
`else
      rx_bit_q <= 1'b0;
`endif
    end else begin
      if (accept) pcnt_q <= '0;
      if (launch) begin
        active_q <= 1'b1;
        cs_q     <= 1'b0;
        sclk_q   <= 1'b0;
        io0_q    <= frame_word[23];
        sh_q     <= {frame_word[22:0], 1'b0};
        bit_q    <= '0;
        div_q    <= '0;
      end else if (active_q) begin
        if (!half_tick) begin
          div_q <= div_q + 16'd1;
        end else begin
          div_q <= '0;
          if (!sclk_q) begin
            sclk_q <= 1'b1;
`ifdef SPI_FLASH_INIT_VERIFY_EN
            rx_q <= {rx_q[6:0], IO1};
`else
            rx_bit_q <= IO1;
`endif
          end else begin
            sclk_q <= 1'b0;
            if (last_bit) begin
              active_q <= 1'b0;
              cs_q     <= 1'b1;
              io0_q    <= 1'b0;
              if ((state_q == RDSR) && (pcnt_q != POLL_MAX)) pcnt_q <= pcnt_q + 8'd1;
            end else begin
              io0_q <= sh_q[23];
              sh_q  <= {sh_q[22:0], 1'b0};
              bit_q <= bit_q + 5'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_init_ctrl.sv
// tb_spi_flash_init_ctrl: directed bench for spi_flash_init_ctrl with a
// mode-0 flash responder and a frame monitor on the SPI pins.
`timescale 1ns/1ps
module tb_spi_flash_init_ctrl;

  localparam int unsigned CLK_DIV    = 1;
  localparam int unsigned CS_GAP     = 4;
  localparam int unsigned POLL_LIMIT = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        start = 1'b0;
  logic [15:0] status_value = '0;
  logic        IO1;
  logic        CS, CLOCK, IO0, IO2, IO3, busy, done, error;
  logic [7:0]  poll_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Monitor/responder bookkeeping (written only by the monitor process).
  int unsigned cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned end_cyc = 0;
  int unsigned cs_falls = 0;
  int unsigned rdsr_total = 0;
  int          frm_bits[$];
  int          frm_low[$];
  int          frm_gap[$];
  logic [23:0] frm_word[$];
  logic        frm_clkok[$];

  // Responder table (written only by the main process).
  logic [7:0]  resp_tab[4];
  int          resp_n;
  int unsigned resp_base;

  always #5 ACLK = ~ACLK;

  spi_flash_init_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .CS_GAP    (CS_GAP),
    .POLL_LIMIT(POLL_LIMIT)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .start       (start),
    .status_value(status_value),
    .CS          (CS),
    .CLOCK       (CLOCK),
    .IO0         (IO0),
    .IO1         (IO1),
    .IO2         (IO2),
    .IO3         (IO3),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .poll_count  (poll_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor and mode-0 responder, sampled on the falling ACLK edge.
  initial begin : monitor
    logic        cs_p, ck_p, done_p;
    logic [23:0] w;
    logic [7:0]  cmd, b;
    int          nb, lowc, highc, idx;
    cs_p = 1'b1; ck_p = 1'b0; done_p = 1'b0;
    w = '0; cmd = '0; b = '0; nb = 0; lowc = 0; highc = 0; idx = 0;
    IO1 = 1'b0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (done && !done_p) done_cyc = cyc;
      if (cs_p && !CS) begin
        nb = 0; w = '0; lowc = 0; cmd = '0;
        cs_falls++;
        frm_gap.push_back(highc);
      end
      if (!CS) begin
        lowc++;
        if (CLOCK && !ck_p) begin
          w = {w[22:0], IO0};
          nb++;
          if (nb == 8) cmd = w[7:0];
        end
        if (!CLOCK && ck_p && nb >= 8 && nb < 16 && cmd == 8'h05) begin
          idx = int'(rdsr_total - resp_base);
          if (idx >= resp_n) idx = resp_n - 1;
          b = resp_tab[idx];
          IO1 = b[15 - nb];
        end
      end
      if (!cs_p && CS) begin
        frm_bits.push_back(nb);
        frm_word.push_back(w);
        frm_low.push_back(lowc);
        frm_clkok.push_back(!CLOCK);
        end_cyc = cyc;
        highc = 0;
        if (nb == 16 && cmd == 8'h05) rdsr_total++;
        IO1 = 1'b0;
      end
      if (CS) highc++;
      cs_p = CS; ck_p = CLOCK; done_p = done;
    end
  end

  task automatic start_run(input logic [15:0] sv);
    @(negedge ACLK);
    status_value = sv;
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    check("acc_busy", busy, 1);
    check("acc_done_clr", done, 0);
    check("acc_err_clr", error, 0);
    check("acc_cs_hi", CS, 1);
    @(posedge ACLK); #1;
    check("acc_cs_low", CS, 0);
    check("acc_io0_b7", IO0, 0);
  endtask

  task automatic wait_done(input string tag);
    int unsigned k;
    k = 0;
    while (!done && k < 4000) begin
      @(negedge ACLK);
      k++;
    end
    check($sformatf("%s_done", tag), done, 1);
    @(negedge ACLK); #1;
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_done_lat", tag), done_cyc - end_cyc, 1);
  endtask

  // Expected frame list: WREN, WRSR, then n_rdsr RDSR frames.
  task automatic check_run(input string tag, input int base, input int n_rdsr, input logic [15:0] sv);
    logic [23:0] ew;
    int          eb;
    check($sformatf("%s_nfrm", tag), frm_word.size() - base, 2 + n_rdsr);
    for (int i = 0; i < 2 + n_rdsr && base + i < frm_word.size(); i++) begin
      ew = (i == 0) ? 24'h000006 : (i == 1) ? {8'h01, sv} : 24'h000500;
      eb = (i == 0) ? 8 : (i == 1) ? 24 : 16;
      check($sformatf("%s_w%0d", tag, i), frm_word[base + i], ew);
      check($sformatf("%s_rises%0d", tag, i), frm_bits[base + i], eb);
      check($sformatf("%s_cslow%0d", tag, i), frm_low[base + i], 2 * eb * CLK_DIV);
      check($sformatf("%s_clkidle%0d", tag, i), frm_clkok[base + i], 1);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), frm_gap[base + i] >= CS_GAP, 1);
    end
  endtask

  initial begin : main
    int          base;
    int unsigned k, falls, pc;
    resp_tab[0] = 8'h00; resp_tab[1] = 8'h00; resp_tab[2] = 8'h00; resp_tab[3] = 8'h00;
    resp_n = 1; resp_base = 0;

    // Reset values
    #1 ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_cs", CS, 1);
    check("rst_clock", CLOCK, 0);
    check("rst_io0", IO0, 0);
    check("rst_io2", IO2, 1);
    check("rst_io3", IO3, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_pcnt", poll_count, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    // Three polls: busy, busy, ready
    resp_tab[0] = 8'h01; resp_tab[1] = 8'h01; resp_tab[2] = 8'h00; resp_n = 3;
    resp_base = rdsr_total;
    base = frm_word.size();
    start_run(16'h0002);
    wait_done("t1");
    check("t1_error", error, 0);
    check("t1_pcnt", poll_count, 3);
    check_run("t1", base, 3, 16'h0002);

    // Busy forever, with an ignored start during polling
    resp_tab[0] = 8'h01; resp_n = 1;
    resp_base = rdsr_total;
    base = frm_word.size();
    start_run(16'h0002);
    k = 0;
    while (rdsr_total - resp_base < 1 && k < 2000) begin
      @(negedge ACLK);
      k++;
    end
    check("t2_first_poll", rdsr_total - resp_base >= 1, 1);
    pc = poll_count;
    check("t2_pcnt_mid", pc, 1);
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    check("t2_ign_pcnt", poll_count, 1);
    check("t2_ign_busy", busy, 1);
    wait_done("t2");
    check("t2_error", error, 1);
    check("t2_pcnt", poll_count, 4);
    check_run("t2", base, 4, 16'h0002);
    falls = cs_falls;
    repeat (60) @(negedge ACLK);
    check("t2_no_5th", cs_falls - falls, 0);
    check("t2_done_sticky", done, 1);
    check("t2_err_sticky", error, 1);

    // Asynchronous reset in the middle of WRSR, then a clean replay
    resp_tab[0] = 8'h00; resp_n = 1;
    resp_base = rdsr_total;
    base = frm_word.size();
    start_run(16'h0302);
    k = 0;
    while (!(frm_word.size() - base >= 1 && !CS && CLOCK) && k < 2000) begin
      @(negedge ACLK);
      k++;
    end
    check("t3_in_wrsr", (frm_word.size() - base >= 1) && !CS && CLOCK, 1);
    repeat (4) @(negedge ACLK);
    #2 ARESET = 1'b1;
    #1;
    check("t3_rst_cs", CS, 1);
    check("t3_rst_clock", CLOCK, 0);
    check("t3_rst_io0", IO0, 0);
    check("t3_rst_busy", busy, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    check("t3_idle_cs", CS, 1);
    resp_base = rdsr_total;
    base = frm_word.size();
    start_run(16'h0302);
    wait_done("t3");
    check("t3_error", error, 0);
    check("t3_pcnt", poll_count, 1);
    check_run("t3", base, 1, 16'h0302);

    // SR1 readback differs from written upper bits
    resp_tab[0] = 8'h00; resp_n = 1;
    resp_base = rdsr_total;
    base = frm_word.size();
    start_run(16'hFC00);
    wait_done("t4");
`ifdef SPI_FLASH_INIT_VERIFY_EN
    check("t4_error", error, 1);
`else
    check("t4_error", error, 0);
`endif
    check("t4_pcnt", poll_count, 1);
    check_run("t4", base, 1, 16'hFC00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
